// File: rtl/zbus_pkg.sv
// zbus_pkg: state encoding and default access wait shared by the Z80 bus arbiter
package zbus_pkg;
   typedef enum logic [2:0] {IDLE, REQ, GRANT, ACCESS, RELEASE} state_t;
   localparam int WAIT_CYC_DEF = 3;
endpackage

// File: rtl/zbus_sync.sv
// zbus_sync: two-flop synchronizer advancing on clock-enable ticks, preset high on reset
module zbus_sync (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic q
);
   logic [1:0] sync_q, sync_d;
   always_comb sync_d = en ? {sync_q[0], d} : sync_q;
   always_ff @(posedge clk)
      if (rst) sync_q <= 2'b11;
      else sync_q <= sync_d;
   assign q = sync_q[1];
endmodule

// File: rtl/zbus_arbiter.sv
// zbus_arbiter: 68k/Z80 bus arbiter; Z80 bank shift register built only with ZBUS_BANK_REG_EN
module zbus_arbiter
   import zbus_pkg::*;
#(
   parameter int WAIT_CYC = WAIT_CYC_DEF
) (
   input  logic       MCLK,
   input  logic       SRES,
   input  logic       MCLK_e,
   input  logic       reg_wr,
   input  logic       reg_sel,
   input  logic       reg_d,
   input  logic       ZBAK,
   input  logic       v_req,
   output logic       v_done,
   output logic       ZBR,
   output logic       ZRES,
   output logic       za_en,
   output logic       bus_status,
   input  logic       z_bank_wr,
   input  logic       z_bank_d,
   output logic [8:0] bank
);
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       busreq_q, busreq_d, zres_q, zres_d, hold_q, hold_d;
   logic       zbr_q, zbr_d, bs_q, bs_d, za_en_q, za_en_d, v_done_q, v_done_d;
   logic       zbak_s;

   zbus_sync u_sync (.clk(MCLK), .rst(SRES), .en(MCLK_e), .d(ZBAK), .q(zbak_s));

   always_comb begin
      busreq_d = (reg_wr && !reg_sel) ? reg_d : busreq_q;
      zres_d   = (reg_wr && reg_sel) ? reg_d : zres_q;
      hold_d   = hold_q && v_req;
      cnt_d    = cnt_q;
      state_d  = state_q;
      unique case (state_q)
         IDLE:    state_d = busreq_q ? REQ : IDLE;
         REQ:     state_d = !busreq_q ? RELEASE : (!zbak_s || !zres_q) ? GRANT : REQ;
         GRANT:
            if (v_req && !hold_q) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_CYC);
            end else if (!busreq_q) state_d = RELEASE;
         ACCESS:
            // a still-high v_req after completion must drop before another access starts
            if (cnt_q == 4'd0) begin
               state_d = GRANT;
               hold_d  = v_req;
            end else cnt_d = cnt_q - 4'd1;
         RELEASE: state_d = (zbak_s || !zres_q) ? IDLE : RELEASE;
         default: state_d = IDLE;
      endcase
      zbr_d    = !(state_d inside {REQ, GRANT, ACCESS});
      bs_d     = !(state_d inside {GRANT, ACCESS});
      za_en_d  = state_d == ACCESS;
      v_done_d = (state_d == ACCESS) && (cnt_d == 4'd0);
   end

   always_ff @(posedge MCLK)
      if (SRES) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         busreq_q <= 1'b0;
         zres_q   <= 1'b0;
         hold_q   <= 1'b0;
         zbr_q    <= 1'b1;
         bs_q     <= 1'b1;
         za_en_q  <= 1'b0;
         v_done_q <= 1'b0;
      end else if (MCLK_e) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busreq_q <= busreq_d;
         zres_q   <= zres_d;
         hold_q   <= hold_d;
         zbr_q    <= zbr_d;
         bs_q     <= bs_d;
         za_en_q  <= za_en_d;
         v_done_q <= v_done_d;
      end

   assign ZBR        = zbr_q;
   assign ZRES       = zres_q;
   assign bus_status = bs_q;
   assign za_en      = za_en_q;
   assign v_done     = v_done_q;

`ifdef ZBUS_BANK_REG_EN
   logic [8:0] bank_q, bank_d;
   always_comb bank_d = (MCLK_e && z_bank_wr) ? {z_bank_d, bank_q[8:1]} : bank_q;
   always_ff @(posedge MCLK)
      if (SRES) bank_q <= 9'h000;
      else bank_q <= bank_d;
   assign bank = bank_q;
`else
   logic bank_unused;
   assign bank_unused = z_bank_wr ^ z_bank_d;
   assign bank = 9'h000;
`endif
endmodule

// File: tb/tb_zbus_arbiter.sv
// tb_zbus_arbiter: scenario tasks plus randomized access timing checked against a tick-count model
module tb_zbus_arbiter;
   localparam int W = 3;
`ifdef ZBUS_BANK_REG_EN
   localparam bit BANK_EN = 1'b1;
`else
   localparam bit BANK_EN = 1'b0;
`endif

   logic MCLK = 1'b0, SRES, MCLK_e, reg_wr, reg_sel, reg_d, ZBAK, v_req, z_bank_wr, z_bank_d;
   logic v_done, ZBR, ZRES, za_en, bus_status;
   logic [8:0] bank;
   int tests = 0, fails = 0;

   zbus_arbiter #(.WAIT_CYC(W)) dut (
      .MCLK(MCLK), .SRES(SRES), .MCLK_e(MCLK_e), .reg_wr(reg_wr), .reg_sel(reg_sel),
      .reg_d(reg_d), .ZBAK(ZBAK), .v_req(v_req), .v_done(v_done), .ZBR(ZBR), .ZRES(ZRES),
      .za_en(za_en), .bus_status(bus_status), .z_bank_wr(z_bank_wr), .z_bank_d(z_bank_d),
      .bank(bank)
   );

   always #5 MCLK = ~MCLK;

   task automatic step();
      MCLK_e = 1'b1;
      @(posedge MCLK);
      #1;
      reg_wr    = 1'b0;
      z_bank_wr = 1'b0;
   endtask

   task automatic idle();
      MCLK_e = 1'b0;
      @(posedge MCLK);
      #1;
      MCLK_e = 1'b1;
   endtask

   task automatic wr_reg(input logic sel, input logic d);
      reg_wr  = 1'b1;
      reg_sel = sel;
      reg_d   = d;
      step();
   endtask

   task automatic do_reset();
      SRES   = 1'b1;
      MCLK_e = 1'b0;
      @(posedge MCLK);
      #1;
      SRES   = 1'b0;
      MCLK_e = 1'b1;
   endtask

   task automatic test_reset();
      SRES = 1'b1; MCLK_e = 1'b0; ZBAK = 1'b0;
      repeat (2) @(posedge MCLK);
      #1;
      tests++;
      if ({ZBR, bus_status, ZRES, za_en, v_done} !== 5'b11000) begin
         fails++;
         $display("FAIL reset_outputs: got %b want 11000", {ZBR, bus_status, ZRES, za_en, v_done});
      end
      tests++;
      if (bank !== 9'h000) begin
         fails++;
         $display("FAIL reset_bank: got %h want 000", bank);
      end
      SRES = 1'b0; MCLK_e = 1'b1; ZBAK = 1'b1;
      step();
   endtask

   task automatic test_grant();
      wr_reg(1'b1, 1'b1);
      tests++;
      if (ZRES !== 1'b1) begin fails++; $display("FAIL zres_write: got %b want 1", ZRES); end
      wr_reg(1'b0, 1'b1);
      tests++;
      if (ZBR !== 1'b1) begin fails++; $display("FAIL zbr_on_write_tick: got %b want 1", ZBR); end
      step();
      tests++;
      if ({ZBR, bus_status} !== 2'b01) begin
         fails++;
         $display("FAIL zbr_after_write: got %b want 01", {ZBR, bus_status});
      end
      step(); step();
      tests++;
      if (bus_status !== 1'b1) begin fails++; $display("FAIL wait_for_ack: got %b want 1", bus_status); end
      ZBAK = 1'b0;
      step();
      repeat (3) idle();
      tests++;
      if (bus_status !== 1'b1) begin fails++; $display("FAIL sync_holds_without_enable: got %b want 1", bus_status); end
      step();
      tests++;
      if (bus_status !== 1'b1) begin fails++; $display("FAIL grant_one_tick_after: got %b want 1", bus_status); end
      step();
      tests++;
      if ({ZBR, bus_status} !== 2'b00) begin
         fails++;
         $display("FAIL grant_two_ticks_after: got %b want 00", {ZBR, bus_status});
      end
   endtask

   task automatic test_access();
      int za_cnt = 0, done_cnt = 0, done_at = -1;
      v_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (za_en === 1'b1) za_cnt++;
         if (v_done === 1'b1) begin done_cnt++; done_at = i; end
      end
      v_req = 1'b0;
      step();
      tests++;
      if (za_cnt != W + 1) begin fails++; $display("FAIL access_za_ticks: got %0d want %0d", za_cnt, W + 1); end
      tests++;
      if (done_cnt != 1) begin fails++; $display("FAIL access_single_done: got %0d want 1", done_cnt); end
      tests++;
      if (done_at != W) begin fails++; $display("FAIL access_done_tick: got %0d want %0d", done_at, W); end
   endtask

   task automatic test_random();
      logic pz = 1'b0, pd = 1'b0, ez, ed;
      for (int n = 0; n < 20; n++) begin
         v_req = 1'b0;
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            step();
            tests++;
            if ({za_en, v_done} !== 2'b00) begin
               fails++;
               $display("FAIL rand_low txn%0d: got %b want 00", n, {za_en, v_done});
            end
         end
         pz = 1'b0; pd = 1'b0;
         v_req = 1'b1;
         for (int i = 0; i <= W + int'($urandom_range(0, 4)); i++) begin
            if ($urandom_range(0, 3) == 0) begin
               idle();
               tests++;
               if ({za_en, v_done} !== {pz, pd}) begin
                  fails++;
                  $display("FAIL rand_hold txn%0d i%0d: got %b want %b", n, i, {za_en, v_done}, {pz, pd});
               end
            end
            step();
            ez = (i <= W);
            ed = (i == W);
            tests++;
            if ({za_en, v_done} !== {ez, ed}) begin
               fails++;
               $display("FAIL rand_access txn%0d i%0d: got %b want %b", n, i, {za_en, v_done}, {ez, ed});
            end
            pz = ez; pd = ed;
         end
      end
      v_req = 1'b0;
      step(); step();
   endtask

   task automatic test_abort();
      logic seen = 1'b0, zbr_at = 1'bx;
      v_req = 1'b1;
      step();
      wr_reg(1'b0, 1'b0);
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (v_done === 1'b1) begin seen = 1'b1; zbr_at = ZBR; end
      end
      tests++;
      if (seen !== 1'b1) begin fails++; $display("FAIL abort_done_seen: got %b want 1", seen); end
      tests++;
      if (zbr_at !== 1'b0) begin fails++; $display("FAIL abort_zbr_at_done: got %b want 0", zbr_at); end
      v_req = 1'b0;
      step(); step();
      tests++;
      if ({ZBR, bus_status} !== 2'b11) begin
         fails++;
         $display("FAIL abort_release: got %b want 11", {ZBR, bus_status});
      end
      wr_reg(1'b0, 1'b1);
      step(); step();
      tests++;
      if (ZBR !== 1'b1) begin fails++; $display("FAIL release_waits_ack: got %b want 1", ZBR); end
      ZBAK = 1'b1;
      step(); step(); step();
      tests++;
      if (ZBR !== 1'b1) begin fails++; $display("FAIL release_to_idle: got %b want 1", ZBR); end
      step();
      tests++;
      if ({ZBR, bus_status} !== 2'b01) begin
         fails++;
         $display("FAIL idle_rerequest: got %b want 01", {ZBR, bus_status});
      end
   endtask

   task automatic test_zres();
      logic seen = 1'b0;
      do_reset();
      ZBAK = 1'b1;
      wr_reg(1'b0, 1'b1);
      step(); step();
      tests++;
      if ({ZBR, bus_status, ZRES} !== 3'b000) begin
         fails++;
         $display("FAIL zres_grant: got %b want 000", {ZBR, bus_status, ZRES});
      end
      v_req = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (v_done === 1'b1) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b1) begin fails++; $display("FAIL zres_access_done: got %b want 1", seen); end
      v_req = 1'b0;
      step(); step();
   endtask

   task automatic test_reset_mid_access();
      v_req = 1'b1;
      step();
      tests++;
      if (za_en !== 1'b1) begin fails++; $display("FAIL mid_access_za: got %b want 1", za_en); end
      SRES = 1'b1; MCLK_e = 1'b0;
      @(posedge MCLK);
      #1;
      tests++;
      if ({za_en, v_done, ZBR} !== 3'b001) begin
         fails++;
         $display("FAIL reset_mid_access: got %b want 001", {za_en, v_done, ZBR});
      end
      SRES = 1'b0; MCLK_e = 1'b1; v_req = 1'b0;
      step();
   endtask

   task automatic test_bank();
      logic [8:0] v;
      logic [8:0] pat;
      do_reset();
      pat = 9'b1_0000_0001;
      for (int k = 0; k < 9; k++) begin
         z_bank_d = pat[k]; z_bank_wr = 1'b1;
         step();
      end
      tests++;
      if (bank !== (BANK_EN ? 9'h101 : 9'h000)) begin
         fails++;
         $display("FAIL bank_101: got %h want %h", bank, BANK_EN ? 9'h101 : 9'h000);
      end
      z_bank_d = 1'b0; z_bank_wr = 1'b1;
      idle();
      z_bank_wr = 1'b0;
      tests++;
      if (bank !== (BANK_EN ? 9'h101 : 9'h000)) begin
         fails++;
         $display("FAIL bank_no_enable: got %h want %h", bank, BANK_EN ? 9'h101 : 9'h000);
      end
      for (int r = 0; r < 4; r++) begin
         v = 9'($urandom);
         for (int k = 0; k < 9; k++) begin
            if ($urandom_range(0, 2) == 0) idle();
            z_bank_d = v[k]; z_bank_wr = 1'b1;
            step();
         end
         tests++;
         if (bank !== (BANK_EN ? v : 9'h000)) begin
            fails++;
            $display("FAIL bank_random%0d: got %h want %h", r, bank, BANK_EN ? v : 9'h000);
         end
      end
   endtask

   initial begin
      SRES = 1'b1; MCLK_e = 1'b0; reg_wr = 1'b0; reg_sel = 1'b0; reg_d = 1'b0;
      ZBAK = 1'b1; v_req = 1'b0; z_bank_wr = 1'b0; z_bank_d = 1'b0;
      test_reset();
      test_grant();
      test_access();
      test_random();
      test_abort();
      test_zres();
      test_reset_mid_access();
      test_bank();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
